// File: rtl/control_encoder.sv
// control_encoder: re-encodes a decoded control vector into its 6-bit opcode,
// registered behind a valid/ready handshake, with saturating statistics.
module control_encoder #(
    parameter int CNT_WIDTH = 16
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 regDst,
    input  logic                 branch,
    input  logic                 memRead,
    input  logic                 memWrite,
    input  logic                 ALUsrc,
    input  logic                 regWrite,
    input  logic                 jump,
    input  logic                 byteOperations,
    input  logic                 move,
    input  logic [2:0]           ALUop,
    input  logic                 branch_ne,
    input  logic                 clear_counts,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [5:0]           out_opcode,
    output logic                 out_illegal,
    output logic [CNT_WIDTH-1:0] encoded_count,
    output logic [CNT_WIDTH-1:0] illegal_count
);

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

    logic [11:0]          ctrl_vec;
    logic                 accept;
    logic [5:0]           enc_opcode;
    logic                 enc_illegal;

    logic                 out_valid_d, out_valid_q;
    logic [5:0]           out_opcode_d, out_opcode_q;
    logic                 out_illegal_d, out_illegal_q;
    logic [CNT_WIDTH-1:0] enc_cnt_d, enc_cnt_q;
    logic [CNT_WIDTH-1:0] ill_cnt_d, ill_cnt_q;

    assign ctrl_vec = {regDst, branch, memRead, memWrite, ALUop,
                       ALUsrc, regWrite, jump, byteOperations, move};

    assign in_ready = !out_valid_q || out_ready;
    assign accept   = in_valid && in_ready;

    // Field order: rd br mr mw alu src rw j b mv
    always_comb begin
        enc_opcode  = 6'b111111;
        enc_illegal = 1'b1;
        casez (ctrl_vec)
            12'b1_0_0_0_111_0_1_0_0_0: enc_opcode = 6'b000000;
            12'b0_0_0_0_101_1_1_0_0_0: enc_opcode = 6'b000010;
            12'b0_0_0_0_110_1_1_0_0_0: enc_opcode = 6'b000011;
            12'b0_0_0_0_000_1_1_0_0_0: enc_opcode = 6'b000100;
            12'b0_0_0_0_001_1_1_0_0_0: enc_opcode = 6'b000101;
            12'b0_0_0_0_100_1_1_0_0_0: enc_opcode = 6'b000111;
            12'b0_0_1_0_101_1_1_0_0_0: enc_opcode = 6'b001000;
            12'b0_0_1_0_101_1_1_0_1_0: enc_opcode = 6'b001001;
            12'b0_0_0_1_101_1_0_0_0_0: enc_opcode = 6'b010000;
            12'b0_0_0_1_101_1_0_0_1_0: enc_opcode = 6'b010001;
            12'b0_1_0_0_110_0_0_0_0_0:
                enc_opcode = branch_ne ? 6'b100111 : 6'b100011;
            12'b0_0_0_0_???_0_0_1_0_0: enc_opcode = 6'b111000;
            12'b0_0_0_0_???_0_1_1_0_0: enc_opcode = 6'b111001;
            12'b0_0_0_0_???_0_1_0_0_1: enc_opcode = 6'b100000;
            default:                   enc_opcode = 6'b111111;
        endcase
        enc_illegal = (enc_opcode == 6'b111111);
    end

    always_comb begin
        out_valid_d   = out_valid_q;
        out_opcode_d  = out_opcode_q;
        out_illegal_d = out_illegal_q;
        enc_cnt_d     = enc_cnt_q;
        ill_cnt_d     = ill_cnt_q;
        if (accept) begin
            out_valid_d   = 1'b1;
            out_opcode_d  = enc_opcode;
            out_illegal_d = enc_illegal;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
        // Clear wins over a same-cycle accept; that item goes uncounted.
        if (clear_counts) begin
            enc_cnt_d = '0;
            ill_cnt_d = '0;
        end else if (accept) begin
            if (enc_cnt_q != CNT_MAX) enc_cnt_d = enc_cnt_q + CNT_ONE;
            if (enc_illegal && ill_cnt_q != CNT_MAX)
                ill_cnt_d = ill_cnt_q + CNT_ONE;
        end
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            out_valid_q   <= 1'b0;
            out_opcode_q  <= 6'b000000;
            out_illegal_q <= 1'b0;
            enc_cnt_q     <= '0;
            ill_cnt_q     <= '0;
        end else begin
            out_valid_q   <= out_valid_d;
            out_opcode_q  <= out_opcode_d;
            out_illegal_q <= out_illegal_d;
            enc_cnt_q     <= enc_cnt_d;
            ill_cnt_q     <= ill_cnt_d;
        end
    end

    assign out_valid     = out_valid_q;
    assign out_opcode    = out_opcode_q;
    assign out_illegal   = out_illegal_q;
    assign encoded_count = enc_cnt_q;
    assign illegal_count = ill_cnt_q;

endmodule

// File: tb/tb_control_encoder.sv
// Bench for control_encoder: forward opcode->control model, scoreboard queue
// of expected outputs, small counters so saturation is reachable.
module tb_control_encoder;

    localparam int CW   = 4;
    localparam int MAXC = 15;

    logic          clock = 1'b0;
    logic          reset_n = 1'b0;
    logic          in_valid = 1'b0;
    logic          in_ready;
    logic [11:0]   vec = '0;
    logic          branch_ne = 1'b0;
    logic          clear_counts = 1'b0;
    logic          out_valid;
    logic          out_ready = 1'b1;
    logic [5:0]    out_opcode;
    logic          out_illegal;
    logic [CW-1:0] encoded_count;
    logic [CW-1:0] illegal_count;

    int         checks = 0;
    int         errors = 0;
    logic [6:0] q[$];
    logic       mv = 1'b0;
    int         enc = 0;
    int         ill = 0;

    always #5 clock = ~clock;

    control_encoder #(.CNT_WIDTH(CW)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .regDst(vec[11]),
        .branch(vec[10]),
        .memRead(vec[9]),
        .memWrite(vec[8]),
        .ALUop(vec[7:5]),
        .ALUsrc(vec[4]),
        .regWrite(vec[3]),
        .jump(vec[2]),
        .byteOperations(vec[1]),
        .move(vec[0]),
        .branch_ne(branch_ne),
        .clear_counts(clear_counts),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_opcode(out_opcode),
        .out_illegal(out_illegal),
        .encoded_count(encoded_count),
        .illegal_count(illegal_count)
    );

    function automatic logic [11:0] mk(input logic rd, input logic br,
        input logic mr, input logic mw, input logic [2:0] alu,
        input logic src, input logic rw, input logic jp, input logic by,
        input logic mvb);
        return {rd, br, mr, mw, alu, src, rw, jp, by, mvb};
    endfunction

    function automatic logic [5:0] op_at(input int i);
        case (i)
            0:       return 6'b000000;
            1:       return 6'b000010;
            2:       return 6'b000011;
            3:       return 6'b000100;
            4:       return 6'b000101;
            5:       return 6'b000111;
            6:       return 6'b001000;
            7:       return 6'b001001;
            8:       return 6'b010000;
            9:       return 6'b010001;
            10:      return 6'b100011;
            11:      return 6'b100111;
            12:      return 6'b111000;
            13:      return 6'b111001;
            default: return 6'b100000;
        endcase
    endfunction

    // Forward control unit: opcode -> control vector; dc fills don't-care ALUop.
    function automatic logic [11:0] ctrl(input logic [5:0] op,
                                         input logic [2:0] dc);
        case (op)
            6'b000000: return mk(1, 0, 0, 0, 3'b111, 0, 1, 0, 0, 0);
            6'b000010: return mk(0, 0, 0, 0, 3'b101, 1, 1, 0, 0, 0);
            6'b000011: return mk(0, 0, 0, 0, 3'b110, 1, 1, 0, 0, 0);
            6'b000100: return mk(0, 0, 0, 0, 3'b000, 1, 1, 0, 0, 0);
            6'b000101: return mk(0, 0, 0, 0, 3'b001, 1, 1, 0, 0, 0);
            6'b000111: return mk(0, 0, 0, 0, 3'b100, 1, 1, 0, 0, 0);
            6'b001000: return mk(0, 0, 1, 0, 3'b101, 1, 1, 0, 0, 0);
            6'b001001: return mk(0, 0, 1, 0, 3'b101, 1, 1, 0, 1, 0);
            6'b010000: return mk(0, 0, 0, 1, 3'b101, 1, 0, 0, 0, 0);
            6'b010001: return mk(0, 0, 0, 1, 3'b101, 1, 0, 0, 1, 0);
            6'b100011: return mk(0, 1, 0, 0, 3'b110, 0, 0, 0, 0, 0);
            6'b100111: return mk(0, 1, 0, 0, 3'b110, 0, 0, 0, 0, 0);
            6'b111000: return mk(0, 0, 0, 0, dc, 0, 0, 1, 0, 0);
            6'b111001: return mk(0, 0, 0, 0, dc, 0, 1, 1, 0, 0);
            6'b100000: return mk(0, 0, 0, 0, dc, 0, 1, 0, 0, 1);
            default:   return 12'h000;
        endcase
    endfunction

    function automatic logic bne_for(input logic [5:0] op, input logic r);
        if (op == 6'b100111) return 1'b1;
        if (op == 6'b100011) return 1'b0;
        return r;
    endfunction

    // One clock: drive at negedge, advance the model at posedge.
    task automatic step(input logic v, input logic [11:0] cv, input logic bn,
                        input logic [6:0] e, input logic ordy,
                        input logic clr);
        logic acc;
        in_valid = v;
        vec = cv;
        branch_ne = bn;
        out_ready = ordy;
        clear_counts = clr;
        acc = v && (!mv || ordy);
        @(posedge clock);
        if (mv && ordy) void'(q.pop_front());
        if (acc) q.push_back(e);
        mv = acc ? 1'b1 : (ordy ? 1'b0 : mv);
        if (clr) begin
            enc = 0;
            ill = 0;
        end else if (acc) begin
            if (enc < MAXC) enc++;
            if (e[6] && ill < MAXC) ill++;
        end
        @(negedge clock);
    endtask

    task automatic test_reset();
        #12;
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_valid got %b want 0", out_valid);
        end
        checks++;
        if (out_opcode !== 6'b000000 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset_out got %b/%b want 000000/0",
                     out_opcode, out_illegal);
        end
        checks++;
        if (encoded_count !== '0 || illegal_count !== '0) begin
            errors++;
            $display("FAIL reset_counts got %0d/%0d want 0/0",
                     encoded_count, illegal_count);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_in_ready got %b want 1", in_ready);
        end
        @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
    endtask

    task automatic test_legal_sweep();
        logic [5:0] op;
        step(0, '0, 0, '0, 1, 1);
        for (int i = 0; i < 15; i++) begin
            op = op_at(i);
            step(1, ctrl(op, 3'($urandom)), bne_for(op, 1'($urandom)),
                 {1'b0, op}, 1, 0);
            checks++;
            if (out_valid !== 1'b1 ||
                {out_illegal, out_opcode} !== q[0]) begin
                errors++;
                $display("FAIL sweep_%0d got v=%b %b/%b want %b",
                         i, out_valid, out_illegal, out_opcode, q[0]);
            end
        end
        step(0, '0, 0, '0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL sweep_drain got %b want 0", out_valid);
        end
        checks++;
        if (encoded_count !== CW'(enc) || illegal_count !== CW'(ill)) begin
            errors++;
            $display("FAIL sweep_counts got %0d/%0d want %0d/%0d",
                     encoded_count, illegal_count, enc, ill);
        end
    endtask

    task automatic test_illegal();
        logic [11:0] bad[3];
        bad[0] = mk(0, 0, 1, 1, 3'b101, 1, 1, 0, 0, 0);
        bad[1] = mk(1, 0, 0, 0, 3'b111, 1, 1, 0, 0, 0);
        bad[2] = 12'h000;
        step(0, '0, 0, '0, 1, 1);
        for (int i = 0; i < 3; i++) begin
            step(1, bad[i], 0, 7'h7F, 1, 0);
            checks++;
            if (out_valid !== 1'b1 ||
                {out_illegal, out_opcode} !== q[0]) begin
                errors++;
                $display("FAIL illegal_%0d got v=%b %b/%b want %b",
                         i, out_valid, out_illegal, out_opcode, q[0]);
            end
        end
        step(0, '0, 0, '0, 1, 0);
        checks++;
        if (illegal_count !== CW'(ill) || encoded_count !== CW'(enc)) begin
            errors++;
            $display("FAIL illegal_counts got %0d/%0d want %0d/%0d",
                     illegal_count, encoded_count, ill, enc);
        end
    endtask

    task automatic test_stall();
        logic [5:0] lw;
        logic [5:0] addi;
        addi = 6'b000010;
        lw = 6'b001000;
        step(1, ctrl(addi, 0), 0, {1'b0, addi}, 1, 0);
        for (int i = 0; i < 5; i++) begin
            step(1, ctrl(lw, 0), 0, {1'b0, lw}, 0, 0);
            checks++;
            if (in_ready !== (!mv || out_ready) || out_valid !== 1'b1 ||
                {out_illegal, out_opcode} !== q[0]) begin
                errors++;
                $display("FAIL stall_%0d got rdy=%b v=%b %b want rdy=0 %b",
                         i, in_ready, out_valid, out_opcode, q[0]);
            end
        end
        step(1, ctrl(lw, 0), 0, {1'b0, lw}, 1, 0);
        checks++;
        if (out_valid !== 1'b1 || {out_illegal, out_opcode} !== q[0]) begin
            errors++;
            $display("FAIL stall_release got v=%b %b want %b",
                     out_valid, out_opcode, q[0]);
        end
        step(0, '0, 0, '0, 1, 0);
        checks++;
        if (out_valid !== 1'b0) begin
            errors++;
            $display("FAIL stall_drain got %b want 0", out_valid);
        end
    endtask

    task automatic test_saturation();
        logic [5:0] op;
        step(0, '0, 0, '0, 1, 1);
        for (int i = 0; i < 20; i++) begin
            op = op_at(int'($urandom_range(0, 14)));
            step(1, ctrl(op, 3'($urandom)), bne_for(op, 1'($urandom)),
                 {1'b0, op}, 1, 0);
            checks++;
            if ({out_illegal, out_opcode} !== q[0] ||
                encoded_count !== CW'(enc)) begin
                errors++;
                $display("FAIL sat_%0d got %b cnt=%0d want %b cnt=%0d",
                         i, out_opcode, encoded_count, q[0], enc);
            end
        end
        op = 6'b010000;
        step(1, ctrl(op, 0), 0, {1'b0, op}, 1, 1);
        checks++;
        if (encoded_count !== '0 || illegal_count !== '0) begin
            errors++;
            $display("FAIL sat_clear got %0d/%0d want 0/0",
                     encoded_count, illegal_count);
        end
        checks++;
        if (out_valid !== 1'b1 || {out_illegal, out_opcode} !== q[0]) begin
            errors++;
            $display("FAIL sat_clear_out got v=%b %b want %b",
                     out_valid, out_opcode, q[0]);
        end
        step(0, '0, 0, '0, 1, 0);
    endtask

    task automatic test_reset_midstream();
        logic [5:0] jop;
        jop = 6'b111000;
        step(1, ctrl(6'b000010, 0), 0, 7'b0000010, 1, 0);
        step(1, ctrl(6'b000100, 0), 0, 7'b0000100, 0, 0);
        reset_n = 1'b0;
        in_valid = 1'b0;
        #1;
        q.delete();
        mv = 1'b0;
        enc = 0;
        ill = 0;
        checks++;
        if (out_valid !== 1'b0 || out_opcode !== 6'b000000) begin
            errors++;
            $display("FAIL rst_mid_out got v=%b %b want 0 000000",
                     out_valid, out_opcode);
        end
        checks++;
        if (encoded_count !== '0 || illegal_count !== '0) begin
            errors++;
            $display("FAIL rst_mid_counts got %0d/%0d want 0/0",
                     encoded_count, illegal_count);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        @(negedge clock);
        step(1, ctrl(jop, 3'b011), 0, {1'b0, jop}, 1, 0);
        checks++;
        if (out_valid !== 1'b1 || {out_illegal, out_opcode} !== q[0] ||
            encoded_count !== CW'(enc)) begin
            errors++;
            $display("FAIL rst_mid_j got v=%b %b cnt=%0d want %b cnt=%0d",
                     out_valid, out_opcode, encoded_count, q[0], enc);
        end
        step(0, '0, 0, '0, 1, 0);
    endtask

    task automatic test_random_roundtrip();
        logic [5:0] op;
        int         k;
        logic       v;
        logic       r;
        for (int i = 0; i < 120; i++) begin
            k = int'($urandom_range(0, 15));
            op = (k == 15) ? 6'b000000 : op_at(k);
            v = ($urandom_range(0, 3) != 0);
            r = ($urandom_range(0, 3) != 0);
            step(v, ctrl(op, 3'($urandom)), bne_for(op, 1'($urandom)),
                 {1'b0, op}, r, 0);
            checks++;
            if (in_ready !== (!mv || out_ready) || out_valid !== mv) begin
                errors++;
                $display("FAIL rand_hs_%0d got rdy=%b v=%b want rdy=%b v=%b",
                         i, in_ready, out_valid, !mv || out_ready, mv);
            end
            if (mv) begin
                checks++;
                if ({out_illegal, out_opcode} !== q[0]) begin
                    errors++;
                    $display("FAIL rand_op_%0d got %b/%b want %b",
                             i, out_illegal, out_opcode, q[0]);
                end
            end
        end
        step(0, '0, 0, '0, 1, 0);
        checks++;
        if (encoded_count !== CW'(enc) || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL rand_end got cnt=%0d v=%b want cnt=%0d v=0",
                     encoded_count, out_valid, enc);
        end
    endtask

    initial begin
        test_reset();
        test_legal_sweep();
        test_illegal();
        test_stall();
        test_saturation();
        test_reset_midstream();
        test_random_roundtrip();
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
